// File: rtl/cache_arbiter_pkg.sv
// Shared types and constants for the I/D cache memory-port arbiter.
package cache_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_I    = 2'd1;
  localparam logic [1:0] GNT_D    = 2'd2;

  localparam logic [3:0] WEN_READ = 4'b0000;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundles the instruction-cache, data-cache and memory-side handshakes of the arbiter.
interface cache_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              inst_cache_req;
  logic [ADDR_W-1:0] inst_cache_addr;
  logic [DATA_W-1:0] inst_cache_rdata;
  logic              inst_cache_dok;

  logic              data_cache_req;
  logic [3:0]        data_cache_wen;
  logic [ADDR_W-1:0] data_cache_addr;
  logic [DATA_W-1:0] data_cache_wdata;
  logic [DATA_W-1:0] data_cache_rdata;
  logic              data_cache_dok;

  logic              mem_req;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_dok;

  // slave is the arbiter's view; master is the surrounding caches plus memory
  modport slave (
    input  inst_cache_req, inst_cache_addr,
    output inst_cache_rdata, inst_cache_dok,
    input  data_cache_req, data_cache_wen, data_cache_addr, data_cache_wdata,
    output data_cache_rdata, data_cache_dok,
    output mem_req, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata, mem_dok
  );

  modport master (
    output inst_cache_req, inst_cache_addr,
    input  inst_cache_rdata, inst_cache_dok,
    output data_cache_req, data_cache_wen, data_cache_addr, data_cache_wdata,
    input  data_cache_rdata, data_cache_dok,
    input  mem_req, mem_wen, mem_addr, mem_wdata,
    output mem_rdata, mem_dok
  );

endinterface

// File: rtl/cache_arbiter_sel.sv
// Grant selection: data wins unless the instruction side has waited out a full streak.
module cache_arb_sel
  import cache_arb_pkg::*;
#(
  parameter int STREAK_MAX = 4,
  parameter int STREAK_W   = $clog2(STREAK_MAX + 1)
) (
  input  logic                inst_req_i,
  input  logic                data_req_i,
  input  logic [STREAK_W-1:0] streak_i,
  output logic [1:0]          grant_o
);

  localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(STREAK_MAX);

  always_comb begin
    grant_o = GNT_NONE;
    if (data_req_i && (!inst_req_i || (streak_i < STREAK_TOP))) begin
      grant_o = GNT_D;
    end else if (inst_req_i) begin
      grant_o = GNT_I;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Merges I-cache and D-cache single-word requests onto one memory port, one transaction at a time.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic            clk,
  input  logic            resetn,
  cache_arbiter_if.slave  bus
);

  localparam int                  STREAK_W   = $clog2(STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(STREAK_MAX);

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                memReq_q, memReq_d;
  logic [3:0]          memWen_q, memWen_d;
  logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
  logic [DATA_W-1:0]   memWdata_q, memWdata_d;
  logic [DATA_W-1:0]   instRdata_q, instRdata_d;
  logic [DATA_W-1:0]   dataRdata_q, dataRdata_d;
  logic                instDok_q, instDok_d;
  logic                dataDok_q, dataDok_d;
  logic [1:0]          grant;

  cache_arb_sel #(
    .STREAK_MAX (STREAK_MAX),
    .STREAK_W   (STREAK_W)
  ) u_sel (
    .inst_req_i (bus.inst_cache_req),
    .data_req_i (bus.data_cache_req),
    .streak_i   (streak_q),
    .grant_o    (grant)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      memReq_q    <= 1'b0;
      memWen_q    <= WEN_READ;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      instRdata_q <= '0;
      dataRdata_q <= '0;
      instDok_q   <= 1'b0;
      dataDok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      memReq_q    <= memReq_d;
      memWen_q    <= memWen_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      instRdata_q <= instRdata_d;
      dataRdata_q <= dataRdata_d;
      instDok_q   <= instDok_d;
      dataDok_q   <= dataDok_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    memReq_d    = memReq_q;
    memWen_d    = memWen_q;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    instRdata_d = instRdata_q;
    dataRdata_d = dataRdata_q;
    instDok_d   = 1'b0;
    dataDok_d   = 1'b0;

    case (state_q)
      IDLE: begin
        case (grant)
          GNT_D: begin
            memReq_d   = 1'b1;
            memWen_d   = bus.data_cache_wen;
            memAddr_d  = bus.data_cache_addr;
            memWdata_d = bus.data_cache_wdata;
            state_d    = BUSY_D;
            // Only count data wins that actually made the instruction side wait
            if (bus.inst_cache_req) begin
              streak_d = (streak_q == STREAK_TOP) ? STREAK_TOP : streak_q + STREAK_W'(1);
            end else begin
              streak_d = '0;
            end
          end
          GNT_I: begin
            memReq_d   = 1'b1;
            memWen_d   = WEN_READ;
            memAddr_d  = bus.inst_cache_addr;
            memWdata_d = '0;
            state_d    = BUSY_I;
            streak_d   = '0;
          end
          default: begin
            streak_d = '0;
          end
        endcase
      end
      BUSY_I: begin
        if (bus.mem_dok) begin
          memReq_d  = 1'b0;
          instDok_d = 1'b1;
          state_d   = RESP_I;
          if (memWen_q == WEN_READ) begin
            instRdata_d = bus.mem_rdata;
          end
        end
      end
      BUSY_D: begin
        if (bus.mem_dok) begin
          memReq_d  = 1'b0;
          dataDok_d = 1'b1;
          state_d   = RESP_D;
          if (memWen_q == WEN_READ) begin
            dataRdata_d = bus.mem_rdata;
          end
        end
      end
      // Requests are still held during the dok cycle, so skip arbitration here
      RESP_I, RESP_D: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_req          = memReq_q;
  assign bus.mem_wen          = memWen_q;
  assign bus.mem_addr         = memAddr_q;
  assign bus.mem_wdata        = memWdata_q;
  assign bus.inst_cache_rdata = instRdata_q;
  assign bus.inst_cache_dok   = instDok_q;
  assign bus.data_cache_rdata = dataRdata_q;
  assign bus.data_cache_dok   = dataDok_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized scoreboard bench for cache_arbiter: a transaction-level model predicts grants and responses.
module tb_cache_arbiter;

  localparam int STREAK_MAX = 4;

  typedef struct {
    bit          side;
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } memTxn_t;

  typedef struct {
    bit          side;
    logic [31:0] rdata;
  } dokTxn_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cache_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  cache_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STREAK_MAX (STREAK_MAX)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  memTxn_t expMem[$];
  dokTxn_t expDok[$];
  req_t    instStim[$];
  req_t    dataStim[$];
  bit      grantLog[$];
  int      grantCyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastDataDokCyc = -1;
  int lastInstDokCyc = -1;

  int          memLat = -1;
  bit          memFixedEn = 1'b0;
  logic [31:0] memFixedRdata = '0;
  bit          memAuto = 1'b1;
  int          spuriousReqs = 0;

  int          mPhase = 0;
  bit          mOwner = 1'b0;
  logic [3:0]  mWen = '0;
  int          mStreak = 0;
  logic [31:0] mRdI = '0;
  logic [31:0] mRdD = '0;
  bit          mPickD;

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(bit side, logic [31:0] addr, logic [3:0] wen, logic [31:0] wdata);
    req_t r;
    r.addr  = addr;
    r.wen   = wen;
    r.wdata = wdata;
    if (side) dataStim.push_back(r);
    else      instStim.push_back(r);
  endtask

  // Requesters: hold each request until its dok, then immediately present the next one
  initial begin
    req_t r;
    bus.inst_cache_req   = 1'b0;
    bus.inst_cache_addr  = '0;
    bus.data_cache_req   = 1'b0;
    bus.data_cache_wen   = '0;
    bus.data_cache_addr  = '0;
    bus.data_cache_wdata = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        bus.inst_cache_req = 1'b0;
        bus.data_cache_req = 1'b0;
        instStim.delete();
        dataStim.delete();
      end else begin
        if (bus.inst_cache_dok) bus.inst_cache_req = 1'b0;
        if (bus.data_cache_dok) bus.data_cache_req = 1'b0;
        if (!bus.inst_cache_req && instStim.size() > 0) begin
          r = instStim.pop_front();
          bus.inst_cache_req  = 1'b1;
          bus.inst_cache_addr = r.addr;
        end
        if (!bus.data_cache_req && dataStim.size() > 0) begin
          r = dataStim.pop_front();
          bus.data_cache_req   = 1'b1;
          bus.data_cache_wen   = r.wen;
          bus.data_cache_addr  = r.addr;
          bus.data_cache_wdata = r.wdata;
        end
      end
    end
  end

  // Memory responder with random or fixed latency, plus on-demand spurious completions
  initial begin
    int memWait;
    int spuriousDone;
    memWait = -1;
    spuriousDone = 0;
    bus.mem_dok   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_dok = 1'b0;
      if (!resetn) begin
        memWait = -1;
      end else if (spuriousDone != spuriousReqs) begin
        bus.mem_dok   = 1'b1;
        bus.mem_rdata = $urandom;
        spuriousDone++;
      end else if (memAuto && bus.mem_req) begin
        if (memWait < 0) memWait = (memLat >= 0) ? memLat : int'($urandom_range(0, 4));
        if (memWait == 0) begin
          bus.mem_dok   = 1'b1;
          bus.mem_rdata = memFixedEn ? memFixedRdata : $urandom;
          memWait = -1;
        end else begin
          memWait--;
        end
      end
    end
  end

  // Reference model: one transaction at a time, data preferred unless inst has waited STREAK_MAX data wins
  initial begin
    forever begin
      @(posedge clk);
      if (!resetn) begin
        mPhase  = 0;
        mStreak = 0;
        mRdI    = '0;
        mRdD    = '0;
        expMem.delete();
        expDok.delete();
      end else if (mPhase == 0) begin
        if (bus.inst_cache_req || bus.data_cache_req) begin
          mPickD = bus.data_cache_req && !(bus.inst_cache_req && mStreak == STREAK_MAX);
          if (mPickD) begin
            expMem.push_back('{1'b1, bus.data_cache_addr, bus.data_cache_wen, bus.data_cache_wdata});
            mOwner  = 1'b1;
            mWen    = bus.data_cache_wen;
            mStreak = bus.inst_cache_req ? ((mStreak < STREAK_MAX) ? mStreak + 1 : STREAK_MAX) : 0;
          end else begin
            expMem.push_back('{1'b0, bus.inst_cache_addr, 4'b0000, 32'h0});
            mOwner  = 1'b0;
            mWen    = 4'b0000;
            mStreak = 0;
          end
          mPhase = 1;
        end else begin
          mStreak = 0;
        end
      end else if (mPhase == 1) begin
        if (bus.mem_dok) begin
          if (mWen == 4'b0000) begin
            if (mOwner) mRdD = bus.mem_rdata;
            else        mRdI = bus.mem_rdata;
          end
          expDok.push_back('{mOwner, mOwner ? mRdD : mRdI});
          mPhase = 2;
        end
      end else begin
        mPhase = 0;
      end
    end
  end

  // Monitor: compares every memory request and every dok pulse against the scoreboard
  initial begin
    memTxn_t cur;
    dokTxn_t e;
    bit      prevReq;
    bit      curValid;
    prevReq  = 1'b0;
    curValid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        prevReq  = 1'b0;
        curValid = 1'b0;
      end else begin
        if (bus.mem_req && !prevReq) begin
          if (expMem.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_grant: got mem_req addr 0x%0h expected no request", bus.mem_addr);
            curValid = 1'b0;
          end else begin
            cur = expMem.pop_front();
            curValid = 1'b1;
            checkOutput("mem_addr", 64'(bus.mem_addr), 64'(cur.addr));
            checkOutput("mem_wen", 64'(bus.mem_wen), 64'(cur.wen));
            checkOutput("mem_wdata", 64'(bus.mem_wdata), 64'(cur.wdata));
          end
          grantLog.push_back(bus.mem_addr[31]);
          grantCyc.push_back(cyc);
        end else if (bus.mem_req && curValid) begin
          checkOutput("mem_addr_stable", 64'(bus.mem_addr), 64'(cur.addr));
          checkOutput("mem_wen_stable", 64'(bus.mem_wen), 64'(cur.wen));
          checkOutput("mem_wdata_stable", 64'(bus.mem_wdata), 64'(cur.wdata));
        end
        prevReq = bus.mem_req;

        if (bus.inst_cache_dok || bus.data_cache_dok) begin
          checkOutput("dok_exclusive", 64'(bus.inst_cache_dok & bus.data_cache_dok), 64'd0);
          if (expDok.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_dok: got inst=%0b data=%0b expected no dok",
                     bus.inst_cache_dok, bus.data_cache_dok);
          end else begin
            e = expDok.pop_front();
            checkOutput("dok_side", 64'(bus.data_cache_dok), 64'(e.side));
            if (e.side) checkOutput("data_rdata", 64'(bus.data_cache_rdata), 64'(e.rdata));
            else        checkOutput("inst_rdata", 64'(bus.inst_cache_rdata), 64'(e.rdata));
          end
          if (bus.data_cache_dok) lastDataDokCyc = cyc;
          if (bus.inst_cache_dok) lastInstDokCyc = cyc;
        end
      end
    end
  end

  task automatic waitDrain(string name);
    int n = 0;
    while ((instStim.size() > 0 || dataStim.size() > 0 || bus.inst_cache_req || bus.data_cache_req ||
            bus.mem_req || expDok.size() > 0 || expMem.size() > 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checkOutput({name, "_drain_timeout"}, 64'(n >= 400), 64'd0);
  endtask

  task automatic checkQuiet(string name);
    checkOutput({name, "_mem_req"}, 64'(bus.mem_req), 64'd0);
    checkOutput({name, "_inst_dok"}, 64'(bus.inst_cache_dok), 64'd0);
    checkOutput({name, "_data_dok"}, 64'(bus.data_cache_dok), 64'd0);
  endtask

  task automatic checkResetValues(string name);
    checkQuiet(name);
    checkOutput({name, "_mem_wen"}, 64'(bus.mem_wen), 64'd0);
    checkOutput({name, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    checkOutput({name, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    checkOutput({name, "_inst_rdata"}, 64'(bus.inst_cache_rdata), 64'd0);
    checkOutput({name, "_data_rdata"}, 64'(bus.data_cache_rdata), 64'd0);
  endtask

  initial begin
    int start;
    int n;
    logic [3:0] w;

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    resetn = 1'b1;
    @(negedge clk);

    $display("[TB] single instruction read");
    memLat = 0;
    memFixedEn = 1'b1;
    memFixedRdata = 32'h3C080001;
    start = grantLog.size();
    applyStimulus(1'b0, 32'h1FC00000, 4'b0000, 32'h0);
    waitDrain("t1");
    checkOutput("t1_grants", 64'(grantLog.size() - start), 64'd1);
    checkOutput("t1_latency", 64'(lastInstDokCyc - grantCyc[start]), 64'd1);
    checkOutput("t1_inst_rdata", 64'(bus.inst_cache_rdata), 64'h3C080001);
    memFixedEn = 1'b0;

    $display("[TB] data write with slow memory");
    memLat = 4;
    start = grantLog.size();
    applyStimulus(1'b1, 32'h80001000, 4'b0011, 32'hDEADBEEF);
    waitDrain("t2");
    checkOutput("t2_grants", 64'(grantLog.size() - start), 64'd1);
    checkOutput("t2_latency", 64'(lastDataDokCyc - grantCyc[start]), 64'd5);
    checkOutput("t2_data_rdata_held", 64'(bus.data_cache_rdata), 64'd0);

    $display("[TB] streak fairness with both sides saturated");
    memLat = -1;
    start = grantLog.size();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'h80000000 | (i << 2), 4'b0000, 32'h0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 32'h00400000 | (i << 2), 4'b0000, 32'h0);
    waitDrain("t3");
    checkOutput("t3_grants", 64'(grantLog.size() - start), 64'd10);
    for (int i = 0; i < 10 && start + i < grantLog.size(); i++) begin
      checkOutput($sformatf("t3_grant_order_%0d", i), 64'(grantLog[start + i]), 64'((i % 5) != 4));
    end

    $display("[TB] simultaneous single requests");
    start = grantLog.size();
    applyStimulus(1'b0, 32'h00500000, 4'b0000, 32'h0);
    applyStimulus(1'b1, 32'h80500000, 4'b0000, 32'h0);
    waitDrain("t4");
    checkOutput("t4_grants", 64'(grantLog.size() - start), 64'd2);
    if (grantLog.size() - start >= 2) begin
      checkOutput("t4_first_is_data", 64'(grantLog[start]), 64'd1);
      checkOutput("t4_second_is_inst", 64'(grantLog[start + 1]), 64'd0);
      checkOutput("t4_gap", 64'(grantCyc[start + 1] - lastDataDokCyc), 64'd2);
    end

    $display("[TB] reset during data transaction");
    memAuto = 1'b0;
    applyStimulus(1'b1, 32'h80600000, 4'b0000, 32'h0);
    n = 0;
    while (!bus.mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5_req_timeout", 64'(n >= 50), 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checkResetValues("t5_reset");
    @(negedge clk);
    resetn = 1'b1;
    spuriousReqs++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkQuiet($sformatf("t5_late_dok_%0d", i));
    end
    memAuto = 1'b1;
    start = grantLog.size();
    applyStimulus(1'b0, 32'h00700000, 4'b0000, 32'h0);
    waitDrain("t5");
    checkOutput("t5_grants", 64'(grantLog.size() - start), 64'd1);
    if (grantLog.size() > start) checkOutput("t5_inst_granted", 64'(grantLog[start]), 64'd0);

    $display("[TB] spurious mem_dok while idle");
    spuriousReqs++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkQuiet($sformatf("t6_spurious_%0d", i));
    end
    checkOutput("t6_inst_rdata", 64'(bus.inst_cache_rdata), 64'(mRdI));
    checkOutput("t6_data_rdata", 64'(bus.data_cache_rdata), 64'(mRdD));

    $display("[TB] randomized traffic");
    memLat = -1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (instStim.size() == 0 && $urandom_range(0, 2) == 0) begin
        applyStimulus(1'b0, $urandom, 4'b0000, 32'h0);
      end
      if (dataStim.size() == 0 && $urandom_range(0, 2) == 0) begin
        w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        applyStimulus(1'b1, $urandom, w, $urandom);
      end
    end
    waitDrain("rand");
    checkOutput("final_expMem_empty", 64'(expMem.size()), 64'd0);
    checkOutput("final_expDok_empty", 64'(expDok.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
